keyboard_renderer: RTL
======================

# keyboard_renderer

Parametrised on-screen keyboard renderer for the synthesizer GUI. After reset it paints the full frame, then idles and repaints only the key columns whose pressed state has changed. It feeds `vga_adapter` directly through `x`, `y`, `colour` and `plot`, and takes its pressed-key vector from the key-scan logic. It replaces the fixed four-key control/datapath pair with a single block of configurable key count and geometry.

## Interface
- `NUM_KEYS`, 8: number of white keys drawn, left to right; `NUM_KEYS*KEY_W <= SCREEN_W`, checked at elaboration.
- `KEY_W`, 20: width of each key column, in pixels.
- `SCREEN_W`, 160: frame width; `SCREEN_H`, 120: frame height.
- `X_W`, 8: `x` width; `Y_W`, 7: `y` width.
- `C_KEY`, 3'b111: idle key colour; `C_PRESSED`, 3'b100: pressed key colour; `C_BORDER`, 3'b000: border, stub and background colour.
- `BLACK_H`, 72: height of the black-key stubs in rows (used only with the macro).
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `pressed_keys` in `NUM_KEYS`: bit k high means key k is pressed; level-sensitive, synchronous to `clock`.
- `x` out `X_W`: pixel column.
- `y` out `Y_W`: pixel row.
- `colour` out 3: pixel colour.
- `plot` out 1: write strobe for the current `x`/`y`/`colour`.
- `busy` out 1: high in every state other than IDLE.
- `frame_done` out 1: one-cycle pulse when the full draw or a key redraw completes.

## Operation
- `pressed_keys` is registered once into `key_q`. `drawn` (`NUM_KEYS` bits) holds the state last painted for each key.
- **FULL_DRAW.** Row-major sweep, x inner, from (0,0) to (`SCREEN_W-1`,`SCREEN_H-1`). Colour is computed with `drawn` = 0. Exit to IDLE with `drawn` <= 0.
- **IDLE.** Computes `diff = key_q ^ drawn`.
  - If `diff` is nonzero, latch k = lowest set bit and `snap = key_q[k]`, then go to KEY_DRAW.
  - Otherwise stay in IDLE.
- **KEY_DRAW.** Sweep x from `k*KEY_W` to `k*KEY_W+KEY_W-1` (inner) and y from 0 to `SCREEN_H-1`. Exit to IDLE with `drawn[k]` <= `snap`.
- Pixel colour at (px,py), with `lx = px - k*KEY_W`:
  - `px >= NUM_KEYS*KEY_W`: `C_BORDER`.
  - `lx == KEY_W-1`, or `py == SCREEN_H-1`: `C_BORDER`.
  - Otherwise: `C_PRESSED` if the key is pressed (KEY_DRAW uses `snap`), else `C_KEY`.
- Key index and `lx` come from an incrementing column/key pair of counters. No divider is used.
- Multiple changed keys are serviced one per pass, lowest index first.
- Changes during a pass are ignored until IDLE. A press followed by a release during a pass leaves `key_q == drawn`, so no extra pass occurs.
- Reset in any state aborts the sweep and restarts with FULL_DRAW.

## Timing
- During reset: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `frame_done`=0, `drawn`=0, `key_q`=0.
- The first cycle after reset is released enters FULL_DRAW with `busy`=1. The first `plot` (pixel 0,0) follows on the next edge.
- Outputs are registered, one pixel per cycle, with `plot` high continuously throughout a pass.
- Full draw is `SCREEN_W*SCREEN_H` = 19200 plots. A key redraw is `KEY_W*SCREEN_H` = 2400 plots.
- `frame_done` pulses in the cycle after the last `plot` of a pass; `busy` drops in that same cycle.
- Key change latency: new value sampled into `key_q` at edge E0, IDLE decides at E1, first `plot` high after E2. Back-to-back passes are separated by exactly 1 IDLE cycle.
- Counters wrap to the pass start position on exit. `x` and `y` never exceed `SCREEN_W-1` and `SCREEN_H-1`.

## Configuration
- `KBD_BLACK_KEYS_EN` defined: for `py < BLACK_H`, pixels with (`lx < 2` and k>0) or (`lx >= KEY_W-3` and k<`NUM_KEYS-1`) are `C_BORDER`, regardless of pressed state. This draws black-key stubs straddling each internal boundary.
- `KBD_BLACK_KEYS_EN` undefined: no stubs; the colour rules above apply unchanged.
- Plot counts and timing are identical in both builds.

## Test plan
- Reset held 3 cycles then released:
  - exactly 19200 `plot` cycles, `frame_done` pulse, `busy`=0;
  - pixel (10,5)=3'b111, (19,5)=3'b000, (10,119)=3'b000.
- `pressed_keys`=8'b0000_0100 from IDLE:
  - first `plot` 3 edges later at (40,0);
  - 2400 plots with x confined to 40..59;
  - (45,30)=3'b100, (59,30)=3'b000.
- Keys 0 and 5 pressed in the same cycle: key 0 pass (x 0..19), 1 IDLE cycle, then key 5 pass (x 100..119); 4800 plots total.
- Key 3 pressed, then released 100 cycles into its pass: pass finishes in `C_PRESSED`, followed by one release pass painting `C_KEY`; then IDLE.
- Reset asserted mid key pass: next cycle all outputs 0. After release, a full 19200-plot draw and `drawn`=0.
- With `KBD_BLACK_KEYS_EN` and key 1 pressed: (20,10)=3'b000, (30,10)=3'b100, (20,80)=3'b100.

Source files
------------

// File: rtl/keyboard_renderer.sv
// On-screen keyboard renderer: paints the full frame after reset, then repaints only the key
// columns whose pressed state changed. Optional black-key stubs via KBD_BLACK_KEYS_EN.
module keyboard_renderer #(
    parameter int unsigned NUM_KEYS  = 8,
    parameter int unsigned KEY_W     = 20,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter logic [2:0]  C_KEY     = 3'b111,
    parameter logic [2:0]  C_PRESSED = 3'b100,
    parameter logic [2:0]  C_BORDER  = 3'b000,
    parameter int unsigned BLACK_H   = 72
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] pressed_keys,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned KW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int unsigned LW  = $clog2(KEY_W + 1);
    localparam int unsigned KIW = $clog2(SCREEN_W + 1);

    if (NUM_KEYS * KEY_W > SCREEN_W) begin : g_bad_width
        $error("keyboard_renderer: NUM_KEYS*KEY_W exceeds SCREEN_W");
    end
    if (BLACK_H > SCREEN_H) begin : g_bad_black
        $error("keyboard_renderer: BLACK_H exceeds SCREEN_H");
    end

    // StDone holds the last pixel on the bus for one cycle before returning to idle.
    typedef enum logic [1:0] {StIdle, StFull, StKey, StDone} state_e;

    state_e              state_q, state_d;
    logic                full_req_q, full_req_d;
    logic [NUM_KEYS-1:0] key_q, drawn_q, drawn_d;
    logic [KW-1:0]       k_q, k_d;
    logic                snap_q, snap_d;
    logic [X_W-1:0]      base_q, base_d;
    logic [X_W-1:0]      cx_q, cx_d;
    logic [Y_W-1:0]      cy_q, cy_d;
    logic [LW-1:0]       lx_q, lx_d;
    logic [KIW-1:0]      kidx_q, kidx_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [2:0]          colour_q, colour_d;
    logic                plot_q, plot_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    logic [NUM_KEYS-1:0] diff;
    logic [KW-1:0]       low_k;
    logic                pix_pressed;
    logic [2:0]          pix_colour;
    logic                last_col, last_row;

    always_comb begin
        diff  = key_q ^ drawn_q;
        low_k = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (diff[i]) low_k = KW'(i);
        end
    end

    // Full draw paints every key as released; a key pass uses the snapshot taken in idle.
    always_comb begin
        pix_pressed = (state_q == StKey) ? snap_q : 1'b0;
        if (kidx_q >= KIW'(NUM_KEYS)) begin
            pix_colour = C_BORDER;
        end else if (lx_q == LW'(KEY_W - 1) || cy_q == Y_W'(SCREEN_H - 1)) begin
            pix_colour = C_BORDER;
`ifdef KBD_BLACK_KEYS_EN
        end else if (cy_q < Y_W'(BLACK_H) &&
                     ((lx_q < LW'(2) && kidx_q != '0) ||
                      (lx_q >= LW'(KEY_W - 3) && kidx_q < KIW'(NUM_KEYS - 1)))) begin
            pix_colour = C_BORDER;
`endif
        end else begin
            pix_colour = pix_pressed ? C_PRESSED : C_KEY;
        end
    end

    always_comb begin
        state_d      = state_q;
        full_req_d   = full_req_q;
        drawn_d      = drawn_q;
        k_d          = k_q;
        snap_d       = snap_q;
        base_d       = base_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        lx_d         = lx_q;
        kidx_d       = kidx_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        frame_done_d = 1'b0;
        last_col     = (state_q == StFull) ? (cx_q == X_W'(SCREEN_W - 1))
                                           : (lx_q == LW'(KEY_W - 1));
        last_row     = (cy_q == Y_W'(SCREEN_H - 1));

        unique case (state_q)
            StIdle: begin
                if (full_req_q) begin
                    state_d    = StFull;
                    full_req_d = 1'b0;
                    cx_d       = '0;
                    cy_d       = '0;
                    lx_d       = '0;
                    kidx_d     = '0;
                end else if (|diff) begin
                    state_d = StKey;
                    k_d     = low_k;
                    snap_d  = key_q[low_k];
                    base_d  = X_W'(32'(low_k) * KEY_W);
                    cx_d    = X_W'(32'(low_k) * KEY_W);
                    cy_d    = '0;
                    lx_d    = '0;
                    kidx_d  = KIW'(low_k);
                end
            end
            StFull, StKey: begin
                x_d      = cx_q;
                y_d      = cy_q;
                colour_d = pix_colour;
                plot_d   = 1'b1;
                if (last_col) begin
                    cx_d   = (state_q == StFull) ? '0 : base_q;
                    lx_d   = '0;
                    kidx_d = (state_q == StFull) ? '0 : kidx_q;
                    if (last_row) begin
                        cy_d    = '0;
                        state_d = StDone;
                        if (state_q == StFull) drawn_d = '0;
                        else                   drawn_d[k_q] = snap_q;
                    end else begin
                        cy_d = cy_q + Y_W'(1);
                    end
                end else begin
                    cx_d = cx_q + X_W'(1);
                    if (lx_q == LW'(KEY_W - 1)) begin
                        lx_d   = '0;
                        kidx_d = kidx_q + KIW'(1);
                    end else begin
                        lx_d = lx_q + LW'(1);
                    end
                end
            end
            StDone: begin
                state_d      = StIdle;
                frame_done_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            full_req_q   <= 1'b1;
            key_q        <= '0;
            drawn_q      <= '0;
            k_q          <= '0;
            snap_q       <= 1'b0;
            base_q       <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            lx_q         <= '0;
            kidx_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_req_q   <= full_req_d;
            key_q        <= pressed_keys;
            drawn_q      <= drawn_d;
            k_q          <= k_d;
            snap_q       <= snap_d;
            base_q       <= base_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            lx_q         <= lx_d;
            kidx_q       <= kidx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
